// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: circular FIFO between the instruction cache and decode.
//
// Parameters:
//   DEPTH - number of entries (power of two, >= 2)
//   XLEN  - width of PC and instruction fields
//
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   flush            - redirect; discards every entry and any same-cycle push/pop
//   in_valid/in_ready, in_pc, in_instr          - fetch-side handshake and entry
//   out_valid/out_ready, out_pc, out_instr,
//   out_misaligned   - decode-side handshake and head entry (zeroed when invalid)
//   count            - number of stored entries
//
// Optional feature: define FETCH_QUEUE_BYPASS_EN to forward an incoming entry straight
// to the outputs in the same cycle when the queue is empty and decode is ready.
// Without it there is no combinational path from in_* to out_*.
module instr_fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_instr,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_instr,
  output logic                     out_misaligned,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [XLEN-1:0] instr_q [DEPTH];
  logic            mis_q   [DEPTH];

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic bypass;
  logic push;
  logic pop;
  logic not_empty;

  assign not_empty = (count_q != '0);
  assign count     = count_q;
  assign in_ready  = (count_q != CntW'(DEPTH));

  // Handshake decode and output muxing.
  always_comb begin
    bypass = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass = !not_empty && in_valid && out_ready && !flush;
`endif
    // A bypassed entry is consumed by decode directly and never stored.
    push = in_valid && in_ready && !bypass && !flush;
    pop  = not_empty && out_ready && !flush;

    out_valid      = 1'b0;
    out_pc         = '0;
    out_instr      = '0;
    out_misaligned = 1'b0;
    if (not_empty) begin
      out_valid      = 1'b1;
      out_pc         = pc_q[rd_ptr_q];
      out_instr      = instr_q[rd_ptr_q];
      out_misaligned = mis_q[rd_ptr_q];
    end else if (bypass) begin
      out_valid      = 1'b1;
      out_pc         = in_pc;
      out_instr      = in_instr;
      out_misaligned = (in_pc[1:0] != 2'b00);
    end
  end

  // Pointer and occupancy next state; flush wins over push and pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
        mis_q[i]   <= 1'b0;
      end
    end else if (push) begin
      pc_q[wr_ptr_q]    <= in_pc;
      instr_q[wr_ptr_q] <= in_instr;
      mis_q[wr_ptr_q]   <= (in_pc[1:0] != 2'b00);
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 32;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_instr;
  logic            in_ready;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic            out_misaligned;
  logic            out_ready;
  logic [2:0]      count;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            mis;
  } ent_t;

  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;

  instr_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_pc          (in_pc),
    .in_instr       (in_instr),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_misaligned (out_misaligned),
    .out_ready      (out_ready),
    .count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output is compared against the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got pc 0x%0h expected no output", out_pc);
      end else begin
        ent_t e;
        e = sb.pop_front();
        chk("sb_pc", out_pc, e.pc);
        chk("sb_instr", out_instr, e.instr);
        chk("sb_mis", {31'd0, out_misaligned}, {31'd0, e.mis});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive an entry; if the bench expects it to be accepted, record it in the scoreboard.
  task automatic present(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] instr,
                         input bit accept, input bit mis);
    ent_t e;
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr;
    if (accept) begin
      e.pc    = pc;
      e.instr = instr;
      e.mis   = mis;
      sb.push_back(e);
    end
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_pc    = '0;
    in_instr = '0;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    idle_in();
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Fill with decode stalled, then try a fifth entry.
    present(32'h0, 32'h1000, 1'b1, 1'b0); step();
    chk("latency1_valid", {31'd0, out_valid}, 32'd1);
    chk("latency1_pc", out_pc, 32'h0);
    present(32'h4, 32'h1001, 1'b1, 1'b0); step();
    present(32'h8, 32'h1002, 1'b1, 1'b0); step();
    present(32'hC, 32'h1003, 1'b1, 1'b0); step();
    chk("full_count", {29'd0, count}, 32'd4);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    present(32'h99, 32'hDEAD, 1'b0, 1'b0); step();
    chk("full_count_hold", {29'd0, count}, 32'd4);
    chk("stall_pc_stable", out_pc, 32'h0);
    chk("stall_instr_stable", out_instr, 32'h1000);
    idle_in();

    // Drain in order.
    out_ready = 1'b1;
    repeat (4) step();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_count", {29'd0, count}, 32'd0);
    chk("empty_pc_zero", out_pc, 32'h0);
    out_ready = 1'b0;

    // Simultaneous push and pop at count==1.
    present(32'h50, 32'h2000, 1'b1, 1'b0); step();
    chk("one_count", {29'd0, count}, 32'd1);
    out_ready = 1'b1;
    present(32'h10, 32'h2001, 1'b1, 1'b0); step();
    chk("pushpop_count", {29'd0, count}, 32'd1);
    chk("pushpop_pc", out_pc, 32'h10);
    idle_in();
    step();
    chk("pushpop_drain", {29'd0, count}, 32'd0);
    out_ready = 1'b0;

    // Flush with three entries and a same-cycle push of 0x20.
    present(32'h60, 32'h3000, 1'b1, 1'b0); step();
    present(32'h64, 32'h3001, 1'b1, 1'b0); step();
    present(32'h68, 32'h3002, 1'b1, 1'b0); step();
    chk("pre_flush_count", {29'd0, count}, 32'd3);
    flush = 1'b1;
    present(32'h20, 32'h3003, 1'b0, 1'b0);
    sb.delete();
    step();
    flush = 1'b0;
    idle_in();
    chk("flush_count", {29'd0, count}, 32'd0);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    repeat (2) step();
    out_ready = 1'b0;

    // Misaligned entry, then asynchronous reset mid-stream.
    present(32'h6, 32'h4000, 1'b1, 1'b1); step();
    chk("mis_flag", {31'd0, out_misaligned}, 32'd1);
    chk("mis_pc", out_pc, 32'h6);
    present(32'h104, 32'h4001, 1'b1, 1'b0); step();
    chk("mid_count", {29'd0, count}, 32'd2);
    out_ready = 1'b1;
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("async_valid", {31'd0, out_valid}, 32'd0);
    chk("async_count", {29'd0, count}, 32'd0);
    chk("async_in_ready", {31'd0, in_ready}, 32'd1);
    chk("async_mis", {31'd0, out_misaligned}, 32'd0);
    out_ready = 1'b0;
    idle_in();
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

    // Empty queue, entry presented with decode ready.
    out_ready = 1'b1;
    present(32'h40, 32'h5000, 1'b1, 1'b0);
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("bypass_valid", {31'd0, out_valid}, 32'd1);
    chk("bypass_pc", out_pc, 32'h40);
    step();
    chk("bypass_count", {29'd0, count}, 32'd0);
    idle_in();
`else
    chk("nobypass_valid", {31'd0, out_valid}, 32'd0);
    chk("nobypass_pc", out_pc, 32'h0);
    step();
    chk("nobypass_count", {29'd0, count}, 32'd1);
    chk("nobypass_next_pc", out_pc, 32'h40);
    idle_in();
    step();
    chk("nobypass_drain", {29'd0, count}, 32'd0);
`endif
    out_ready = 1'b0;
    step();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
